get_data_pipe: RTL and testbench
================================

// Module: get_data_pipe
// PURPOSE
//  Clocked, parametrised successor of the combinational fetch stage. Accepts one (i,z,k,l,addr,position) tuple per
//  valid/ready transfer, issues the reads the position requires to rom_C and rom_read_and_D, waits ROM_LAT cycles,
//  then presents tuple+fetched data on a valid/ready output. Sits between get_param and the compute stage.
// PARAMETERS
//  IDX_W   8   width of i/z/k/l and of addr_rom_read_and_D
//  ADDR_W  12  width of parameter address
//  POS_W   5   width of position code (values = `config.v` position macros)
//  C_W     8   rom_C data width;  D_W 8  d_i width;  READ_W 2  read_i width
//  ROM_LAT 1   cycles from ce/addr cycle to valid ROM data (1..7)
// PORTS
//  clk  in 1 clock;  rst  in 1 synchronous active-high reset
//  in_valid in 1 / in_ready out 1: input handshake
//  i_in,z_in,k_in,l_in in IDX_W; addr_in in ADDR_W; position_in in POS_W: tuple from get_param
//  ce_rom_C out 1; addr_rom_C out 2; data in C_W: rom_C port (symbol A/C/G/T = 0/1/2/3)
//  ce_rom_read_and_D out 1; addr_rom_read_and_D out IDX_W; d_i in D_W; read_i in READ_W: rom_read_and_D port
//  out_valid out 1 / out_ready in 1: output handshake
//  i_out,z_out,k_out,l_out out IDX_W; addr_out out ADDR_W; position_out out POS_W: registered tuple copy
//  d_i_out out D_W; read_i_out out READ_W; C_out out C_W: fetched data
// BEHAVIOUR
//  Clock/reset: one clk; rst synchronous, active-high. rst wins over every other event.
//  Reset values: all outputs 0 except in_ready=1 after reset; state=IDLE; cache invalid.
//  Decode (at acceptance): NONE -> D_ONLY (D @ i_in); X_INSERTION -> C_ONLY (C @ sym X);
//   X_DELETION -> C_RD (C @ sym X, read/D @ i_in); STOP_1/2, *_MATCH, *_SNP, undefined -> NO_ROM.
//  FSM: IDLE -> (accept) ISSUE | HOLD ; ISSUE -> WAIT ; WAIT -> HOLD after ROM_LAT cycles ; HOLD -> IDLE on out_ready.
//  in_ready=1 only in IDLE. Accept = in_valid & in_ready at edge T; tuple registered into *_out at T.
//  ISSUE (cycle T+1): required ce_* high exactly one cycle, addresses valid same cycle; unused ce low, its addr 0.
//  Capture at T+1+ROM_LAT: D_ONLY -> d_i_out; C_ONLY -> C_out; C_RD -> C_out and read_i_out. Fields not fetched = 0.
//  Latency: ROM class out_valid first high at T+2+ROM_LAT (T+3 at ROM_LAT=1); NO_ROM out_valid at T+1, data fields 0.
//  HOLD: out_valid=1 and all *_out stable until out_valid&out_ready; in_ready returns 1 the next cycle (IDLE).
//  ROM ce never asserted outside ISSUE. ROM inputs ignored outside capture cycle.
//  Reset mid-operation (ISSUE/WAIT/HOLD): abort, drop in-flight ROM data, outputs to reset values, no out_valid.
//  in_valid while busy: ignored (not accepted), upstream must hold tuple.
// CONFIGURATION
//  GET_DATA_C_CACHE_EN defined: 4-entry C cache (one per symbol, valid bit each), filled on every rom_C capture.
//   C_ONLY with valid entry: no ISSUE, no ce_rom_C; C_out=cached value, out_valid at T+1.
//   C_RD always reads ROM (read_i needed) and refreshes entry. rst clears all valid bits.
//  Undefined: no cache; C_ONLY always takes ROM path with ROM-class latency.
// TESTING
//  1 rst held 2 cycles mid-WAIT -> next cycle all outputs 0, in_ready=1, no out_valid, no ce pulse after.
//  2 NONE, i_in=8'h2A, d_i=8'h5C, ROM_LAT=1 -> ce_rom_read_and_D=1 at T+1 addr 8'h2A only; out_valid at T+3,
//    d_i_out=8'h5C, C_out=0, read_i_out=0, i_out=8'h2A.
//  3 G_DELETION, i_in=8'h10, data=8'h33, read_i=2'b10 -> both ce high at T+1, addr_rom_C=2'b10;
//    out C_out=8'h33, read_i_out=2'b10, d_i_out=0.
//  4 A_MATCH -> no ce at any cycle; out_valid at T+1, d_i_out=C_out=read_i_out=0, tuple passed through.
//  5 out_ready held 0 for 5 cycles after out_valid -> out_valid and all *_out stable, in_ready=0, new in_valid
//    not accepted; out_ready=1 -> transfer, in_ready=1 next cycle.
//  6 GET_DATA_C_CACHE_EN: T_INSERTION (data=8'h7E) twice -> 2nd: no ce_rom_C, out_valid at T+1, C_out=8'h7E;
//    after rst third T_INSERTION reads ROM again. Sweep ROM_LAT=1,3.

Source files
------------

// File: rtl/get_data_pipe.sv
// get_data_pipe: registered fetch stage between get_param and the compute stage.
// Optional macro GET_DATA_C_CACHE_EN adds a 4-entry cache of rom_C results (one per symbol).
module get_data_pipe #(
  parameter int IDX_W   = 8,
  parameter int ADDR_W  = 12,
  parameter int POS_W   = 5,
  parameter int C_W     = 8,
  parameter int D_W     = 8,
  parameter int READ_W  = 2,
  parameter int ROM_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IDX_W-1:0]   i_in,
  input  logic [IDX_W-1:0]   z_in,
  input  logic [IDX_W-1:0]   k_in,
  input  logic [IDX_W-1:0]   l_in,
  input  logic [ADDR_W-1:0]  addr_in,
  input  logic [POS_W-1:0]   position_in,
  output logic               ce_rom_C,
  output logic [1:0]         addr_rom_C,
  input  logic [C_W-1:0]     data,
  output logic               ce_rom_read_and_D,
  output logic [IDX_W-1:0]   addr_rom_read_and_D,
  input  logic [D_W-1:0]     d_i,
  input  logic [READ_W-1:0]  read_i,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [IDX_W-1:0]   i_out,
  output logic [IDX_W-1:0]   z_out,
  output logic [IDX_W-1:0]   k_out,
  output logic [IDX_W-1:0]   l_out,
  output logic [ADDR_W-1:0]  addr_out,
  output logic [POS_W-1:0]   position_out,
  output logic [D_W-1:0]     d_i_out,
  output logic [READ_W-1:0]  read_i_out,
  output logic [C_W-1:0]     C_out
);

  // Position codes as laid out in config.v: NONE, 4x MATCH, 4x INSERTION, 4x DELETION, 4x SNP, STOP_1, STOP_2.
  localparam logic [POS_W-1:0] POS_NONE  = POS_W'(0);
  localparam logic [POS_W-1:0] POS_A_INS = POS_W'(5);
  localparam logic [POS_W-1:0] POS_T_INS = POS_W'(8);
  localparam logic [POS_W-1:0] POS_A_DEL = POS_W'(9);
  localparam logic [POS_W-1:0] POS_T_DEL = POS_W'(12);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD} state_t;
  typedef enum logic [1:0] {NO_ROM, D_ONLY, C_ONLY, C_RD} fetch_t;

  state_t      r_state;
  fetch_t      r_class;
  logic [2:0]  r_waitCnt;
  fetch_t      w_class;
  logic [1:0]  w_sym;
  logic        w_hit;

  always_comb begin
    w_class = NO_ROM;
    w_sym   = 2'd0;
    if (position_in == POS_NONE) begin
      w_class = D_ONLY;
    end else if (position_in >= POS_A_INS && position_in <= POS_T_INS) begin
      w_class = C_ONLY;
      w_sym   = 2'(position_in - POS_A_INS);
    end else if (position_in >= POS_A_DEL && position_in <= POS_T_DEL) begin
      w_class = C_RD;
      w_sym   = 2'(position_in - POS_A_DEL);
    end
  end

`ifdef GET_DATA_C_CACHE_EN
  logic [C_W-1:0] r_cacheVal [4];
  logic [3:0]     r_cacheValid;
  logic [1:0]     r_sym;
  assign w_hit = (w_class == C_ONLY) && r_cacheValid[w_sym];
`else
  assign w_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state             <= S_IDLE;
      r_class             <= NO_ROM;
      r_waitCnt           <= 3'd0;
      in_ready            <= 1'b1;
      out_valid           <= 1'b0;
      ce_rom_C            <= 1'b0;
      addr_rom_C          <= 2'd0;
      ce_rom_read_and_D   <= 1'b0;
      addr_rom_read_and_D <= '0;
      i_out               <= '0;
      z_out               <= '0;
      k_out               <= '0;
      l_out               <= '0;
      addr_out            <= '0;
      position_out        <= '0;
      d_i_out             <= '0;
      read_i_out          <= '0;
      C_out               <= '0;
`ifdef GET_DATA_C_CACHE_EN
      r_cacheValid        <= 4'd0;
      r_sym               <= 2'd0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            i_out        <= i_in;
            z_out        <= z_in;
            k_out        <= k_in;
            l_out        <= l_in;
            addr_out     <= addr_in;
            position_out <= position_in;
            d_i_out      <= '0;
            read_i_out   <= '0;
            C_out        <= '0;
            in_ready     <= 1'b0;
            r_class      <= w_class;
`ifdef GET_DATA_C_CACHE_EN
            r_sym        <= w_sym;
            if (w_hit) C_out <= r_cacheVal[w_sym];
`endif
            // Cache hits behave like NO_ROM: straight to HOLD without touching the ROMs.
            if (w_class == NO_ROM || w_hit) begin
              out_valid <= 1'b1;
              r_state   <= S_HOLD;
            end else begin
              ce_rom_C            <= (w_class != D_ONLY);
              addr_rom_C          <= (w_class != D_ONLY) ? w_sym : 2'd0;
              ce_rom_read_and_D   <= (w_class != C_ONLY);
              addr_rom_read_and_D <= (w_class != C_ONLY) ? i_in : '0;
              r_state             <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          ce_rom_C            <= 1'b0;
          addr_rom_C          <= 2'd0;
          ce_rom_read_and_D   <= 1'b0;
          addr_rom_read_and_D <= '0;
          r_waitCnt           <= 3'd1;
          r_state             <= S_WAIT;
        end
        S_WAIT: begin
          if (r_waitCnt == 3'(ROM_LAT)) begin
            case (r_class)
              D_ONLY: d_i_out <= d_i;
              C_ONLY: C_out   <= data;
              C_RD: begin
                C_out      <= data;
                read_i_out <= read_i;
              end
              default: ;
            endcase
`ifdef GET_DATA_C_CACHE_EN
            if (r_class == C_ONLY || r_class == C_RD) begin
              r_cacheVal[r_sym]   <= data;
              r_cacheValid[r_sym] <= 1'b1;
            end
`endif
            out_valid <= 1'b1;
            r_state   <= S_HOLD;
          end else begin
            r_waitCnt <= r_waitCnt + 3'd1;
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_get_data_pipe.sv
// Scoreboard bench for get_data_pipe: two lanes (ROM_LAT 1 and 3), each with its own DUT, ROM model and monitor.
module tb_get_data_pipe;

  int nTests = 0;
  int nFail  = 0;
  logic clk = 1'b0;
  int cyc = 0;
  bit laneDone [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]  i, z, k, l;
    logic [11:0] addr;
    logic [4:0]  pos;
    logic [7:0]  d, c;
    logic [1:0]  r, sym;
    int          lat, accept, nCeC, nCeD;
  } expT;

`ifdef GET_DATA_C_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  localparam logic [4:0] P_NONE = 5'd0, P_A_MATCH = 5'd1, P_T_INS = 5'd8, P_G_DEL = 5'd11, P_STOP_1 = 5'd17;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int LAT = (g == 0) ? 1 : 3;

    logic rst, in_valid, in_ready, out_valid, out_ready;
    logic [7:0]  i_in, z_in, k_in, l_in, i_out, z_out, k_out, l_out;
    logic [11:0] addr_in, addr_out;
    logic [4:0]  position_in, position_out;
    logic        ce_rom_C, ce_rom_read_and_D;
    logic [1:0]  addr_rom_C, read_i, read_i_out;
    logic [7:0]  addr_rom_read_and_D, data, d_i, d_i_out, C_out;

    get_data_pipe #(.ROM_LAT(LAT)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .i_in(i_in), .z_in(z_in), .k_in(k_in), .l_in(l_in), .addr_in(addr_in), .position_in(position_in),
      .ce_rom_C(ce_rom_C), .addr_rom_C(addr_rom_C), .data(data),
      .ce_rom_read_and_D(ce_rom_read_and_D), .addr_rom_read_and_D(addr_rom_read_and_D),
      .d_i(d_i), .read_i(read_i),
      .out_valid(out_valid), .out_ready(out_ready),
      .i_out(i_out), .z_out(z_out), .k_out(k_out), .l_out(l_out), .addr_out(addr_out),
      .position_out(position_out), .d_i_out(d_i_out), .read_i_out(read_i_out), .C_out(C_out)
    );

    logic [7:0] romC [4];
    logic [7:0] romD [256];
    logic [1:0] romR [256];
    bit         hCeC [LAT];
    bit         hCeD [LAT];
    logic [1:0] hAddrC [LAT];
    logic [7:0] hAddrD [LAT];

    expT  q[$];
    expT  cur;
    bit   inFlight = 1'b0;
    bit   lockRom = 1'b0;
    int   ceCCount = 0, ceDCount = 0, forceStall = 0;
    bit   cacheValid [4];
    logic [7:0] cacheVal [4];

    function automatic logic [127:0] outBus();
      return 128'({i_out, z_out, k_out, l_out, addr_out, position_out, d_i_out, read_i_out, C_out});
    endfunction

    // ROM model: data for a ce seen at edge E is driven only for the sample at edge E+LAT, noise otherwise.
    always @(negedge clk) begin
      data   <= hCeC[LAT-1] ? romC[hAddrC[LAT-1]] : 8'($urandom);
      d_i    <= hCeD[LAT-1] ? romD[hAddrD[LAT-1]] : 8'($urandom);
      read_i <= hCeD[LAT-1] ? romR[hAddrD[LAT-1]] : 2'($urandom);
      for (int s = LAT - 1; s > 0; s--) begin
        hCeC[s]   <= hCeC[s-1];
        hCeD[s]   <= hCeD[s-1];
        hAddrC[s] <= hAddrC[s-1];
        hAddrD[s] <= hAddrD[s-1];
      end
      hCeC[0]   <= ce_rom_C;
      hCeD[0]   <= ce_rom_read_and_D;
      hAddrC[0] <= addr_rom_C;
      hAddrD[0] <= addr_rom_read_and_D;
    end

    // Reference model: what the fetch must return, decided from the position code at acceptance.
    function automatic expT predict(input logic [4:0] pos, input logic [7:0] iv);
      expT e;
      int p = int'(pos);
      e.i = iv; e.pos = pos; e.d = 8'd0; e.c = 8'd0; e.r = 2'd0; e.sym = 2'd0;
      e.lat = 1; e.nCeC = 0; e.nCeD = 0;
      if (p == 0) begin
        e.d = romD[iv]; e.nCeD = 1; e.lat = 2 + LAT;
      end else if (p >= 5 && p <= 8) begin
        e.sym = 2'(p - 5);
        if (CACHE && cacheValid[e.sym]) e.c = cacheVal[e.sym];
        else begin
          e.c = romC[e.sym]; e.nCeC = 1; e.lat = 2 + LAT;
          cacheValid[e.sym] = 1'b1; cacheVal[e.sym] = e.c;
        end
      end else if (p >= 9 && p <= 12) begin
        e.sym = 2'(p - 9);
        e.c = romC[e.sym]; e.r = romR[iv]; e.nCeC = 1; e.nCeD = 1; e.lat = 2 + LAT;
        cacheValid[e.sym] = 1'b1; cacheVal[e.sym] = e.c;
      end
      return e;
    endfunction

    task automatic applyStimulus(input logic [4:0] pos, input logic [7:0] iv);
      expT e;
      bit ok = 1'b0;
      logic [7:0] z = 8'($urandom), k = 8'($urandom), l = 8'($urandom);
      logic [11:0] a = 12'($urandom);
      for (int t = 0; t < 200 && !ok; t++) begin
        @(negedge clk);
        i_in = iv; z_in = z; k_in = k; l_in = l; addr_in = a; position_in = pos; in_valid = 1'b1;
        ok = in_ready;
      end
      if (!ok) begin
        checkOutput($sformatf("L%0d accept timeout", LAT), 128'(in_ready), 128'(1));
        in_valid = 1'b0;
        return;
      end
      if (!lockRom && $urandom_range(0, 3) == 0) romC[2'($urandom_range(0, 3))] = 8'($urandom);
      e = predict(pos, iv);
      e.z = z; e.k = k; e.l = l; e.addr = a; e.accept = cyc + 1;
      q.push_back(e);
      cur = e;
      inFlight = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
    endtask

    task automatic resetDut(input int n);
      rst = 1'b1; in_valid = 1'b0;
      q.delete(); inFlight = 1'b0; ceCCount = 0; ceDCount = 0;
      for (int s = 0; s < 4; s++) cacheValid[s] = 1'b0;
      repeat (n) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      checkOutput($sformatf("L%0d reset outputs", LAT),
                  {outBus(), 59'd0} | 128'({out_valid, ce_rom_C, addr_rom_C, ce_rom_read_and_D, addr_rom_read_and_D}),
                  128'(0));
      checkOutput($sformatf("L%0d reset in_ready", LAT), 128'(in_ready), 128'(1));
    endtask

    task automatic waitIdle();
      int t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!(in_ready && q.size() == 0) && t < 300);
      checkOutput($sformatf("L%0d drain", LAT), 128'(q.size()), 128'(0));
    endtask

    // Monitor: ROM-port checks every cycle, scoreboard pop on each new output, hold stability while stalled.
    initial begin
      bit holding = 1'b0, expectReadyNext = 1'b0;
      int stall = 0;
      logic [127:0] held = '0;
      expT e;
      out_ready = 1'b0;
      forever begin
        @(negedge clk);
        if (rst) begin
          holding = 1'b0; expectReadyNext = 1'b0; out_ready = 1'b0;
        end else begin
          if (expectReadyNext) checkOutput($sformatf("L%0d in_ready after transfer", LAT), 128'(in_ready), 128'(1));
          expectReadyNext = 1'b0;
          if (ce_rom_C || ce_rom_read_and_D) begin
            checkOutput($sformatf("L%0d ce while idle", LAT), 128'(inFlight), 128'(1));
            checkOutput($sformatf("L%0d ce timing", LAT), 128'(cyc + 1), 128'(cur.accept + 1));
          end
          if (ce_rom_C) begin
            ceCCount++;
            checkOutput($sformatf("L%0d addr_rom_C", LAT), 128'(addr_rom_C), 128'(cur.sym));
          end else if (ce_rom_read_and_D) checkOutput($sformatf("L%0d unused addr_rom_C", LAT), 128'(addr_rom_C), 128'(0));
          if (ce_rom_read_and_D) begin
            ceDCount++;
            checkOutput($sformatf("L%0d addr_rom_read_and_D", LAT), 128'(addr_rom_read_and_D), 128'(cur.i));
          end else if (ce_rom_C) checkOutput($sformatf("L%0d unused addr_rom_read_and_D", LAT), 128'(addr_rom_read_and_D), 128'(0));
          if (out_valid) begin
            checkOutput($sformatf("L%0d in_ready while busy", LAT), 128'(in_ready), 128'(0));
            if (!holding) begin
              checkOutput($sformatf("L%0d expected item present", LAT), 128'(q.size() != 0), 128'(1));
              if (q.size() != 0) begin
                e = q.pop_front();
                checkOutput($sformatf("L%0d output fields pos=%0d", LAT, e.pos), outBus(),
                            128'({e.i, e.z, e.k, e.l, e.addr, e.pos, e.d, e.r, e.c}));
                checkOutput($sformatf("L%0d latency pos=%0d", LAT, e.pos), 128'(cyc + 1 - e.accept), 128'(e.lat));
                checkOutput($sformatf("L%0d ce_rom_C pulses", LAT), 128'(ceCCount), 128'(e.nCeC));
                checkOutput($sformatf("L%0d ce_rom_read_and_D pulses", LAT), 128'(ceDCount), 128'(e.nCeD));
                ceCCount = 0; ceDCount = 0; inFlight = 1'b0;
                held = outBus();
                holding = 1'b1;
                stall = (forceStall > 0) ? forceStall : (($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0);
                forceStall = 0;
              end
            end else begin
              checkOutput($sformatf("L%0d hold stability", LAT), outBus(), held);
            end
            if (stall > 0) begin
              out_ready = 1'b0; stall--;
            end else begin
              out_ready = 1'b1; holding = 1'b0; expectReadyNext = 1'b1;
            end
          end else begin
            if (holding) checkOutput($sformatf("L%0d out_valid held", LAT), 128'(out_valid), 128'(1));
            holding = 1'b0;
            out_ready = 1'($urandom_range(0, 1));
          end
        end
      end
    end

    initial begin
      in_valid = 1'b0; i_in = '0; z_in = '0; k_in = '0; l_in = '0; addr_in = '0; position_in = '0;
      for (int s = 0; s < 4; s++) romC[s] = 8'($urandom);
      for (int s = 0; s < 256; s++) begin romD[s] = 8'($urandom); romR[s] = 2'($urandom); end
      resetDut(3);

      romD[8'h2A] = 8'h5C;
      applyStimulus(P_NONE, 8'h2A);
      lockRom = 1'b1;
      romC[2] = 8'h33; romR[8'h10] = 2'b10;
      applyStimulus(P_G_DEL, 8'h10);
      applyStimulus(P_A_MATCH, 8'($urandom));
      waitIdle();
      forceStall = 5;
      applyStimulus(P_STOP_1, 8'($urandom));
      applyStimulus(P_NONE, 8'($urandom));
      waitIdle();

      romC[3] = 8'h7E;
      applyStimulus(P_T_INS, 8'($urandom));
      applyStimulus(P_T_INS, 8'($urandom));
      waitIdle();
      resetDut(1);
      applyStimulus(P_T_INS, 8'($urandom));
      waitIdle();
      lockRom = 1'b0;

      for (int n = 0; n < 80; n++) applyStimulus(5'($urandom_range(0, 24)), 8'($urandom));
      waitIdle();

      applyStimulus(P_NONE, 8'($urandom));
      @(negedge clk);
      @(negedge clk);
      resetDut(2);
      for (int n = 0; n < 8; n++) begin
        @(negedge clk);
        checkOutput($sformatf("L%0d no out_valid after reset", LAT), 128'(out_valid), 128'(0));
        checkOutput($sformatf("L%0d no ce after reset", LAT), 128'({ce_rom_C, ce_rom_read_and_D}), 128'(0));
      end

      for (int n = 0; n < 20; n++) applyStimulus(5'($urandom_range(0, 24)), 8'($urandom));
      waitIdle();
      laneDone[g] = 1'b1;
    end
  end

  initial begin
    int t = 0;
    while (!(laneDone[0] && laneDone[1]) && t < 40000) begin
      @(posedge clk);
      t++;
    end
    checkOutput("lanes finished", 128'({laneDone[0], laneDone[1]}), 128'(3));
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
